reg4_scan_seq: RTL and testbench
================================

Name: reg4_scan_seq

Overview:
- Upstream stage of the registered 4:1 16-bit output mux.
- Holds four 16-bit data registers that drive the mux's four data inputs.
- Generates the mux's 2-bit select as a timed round-robin scan, dwelling a programmable number of cycles per slot.
- Registers are loaded through a simple write port; scanning is started and stopped by single-cycle commands.

Parameters:
- WIDTH, 16, data width of each slot register and the write port.
- DWELL, 4, cycles o_ctrl stays on one slot before advancing; legal range 1..255.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_wr_en  input  1  write strobe for a slot register.
- i_wr_addr  input  2  slot index written when i_wr_en=1.
- i_wr_data  input  WIDTH  value written.
- i_start  input  1  1-cycle pulse; begin scanning.
- i_stop  input  1  1-cycle pulse; request end of scan.
- o_data_0  output  WIDTH  slot 0 register, to mux input 0.
- o_data_1  output  WIDTH  slot 1 register, to mux input 1.
- o_data_2  output  WIDTH  slot 2 register, to mux input 2.
- o_data_3  output  WIDTH  slot 3 register, to mux input 3.
- o_ctrl  output  2  current slot select, to mux i_ctrl.
- o_busy  output  1  1 while in SCAN or STOPPING.
- o_wrap  output  1  1-cycle pulse when o_ctrl advances 3->0.

Behaviour:
- Reset (i_rst=1, asynchronous, active-high):
  - o_data_0..3=0, o_ctrl=0, o_busy=0, o_wrap=0.
  - Dwell counter=0, FSM=IDLE.
  - Reset mid-scan aborts immediately; there is no drain.
- Write port:
  - i_wr_en=1 loads slot[i_wr_addr] at the clock edge; the new value appears on o_data_n the following cycle.
  - Writes are accepted in every FSM state.
  - A write to the currently selected slot is legal; the mux sees the new value on its next edge.
- Counter: an 8-bit dwell counter, cnt.
- IDLE:
  - o_ctrl=0, o_busy=0, cnt=0.
  - i_start=1 with i_stop=0 -> SCAN; o_ctrl=0, cnt=0.
  - i_start and i_stop asserted together -> stop wins; remain in IDLE.
- SCAN:
  - o_busy=1; cnt increments each cycle.
  - When cnt==DWELL-1: cnt<=0 and o_ctrl<=o_ctrl+1 (mod 4).
  - The 3->0 transition asserts o_wrap for exactly the first cycle in which o_ctrl==0.
  - Each slot is therefore held for exactly DWELL cycles.
  - DWELL=1 advances o_ctrl every cycle.
  - i_start while in SCAN is ignored; it does not restart the dwell.
  - i_stop -> STOPPING; cnt continues counting.
  - If i_stop arrives on the cycle where cnt==DWELL-1: the advance is suppressed, and the block goes directly to IDLE with o_ctrl=0.
- STOPPING:
  - o_busy=1; the current slot finishes its dwell.
  - At cnt==DWELL-1 -> IDLE, o_ctrl<=0, cnt<=0, no advance, o_wrap=0.
  - i_start and i_stop are ignored in this state.
- All outputs are registered; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro: REG4_SCAN_MASK_EN.
- Defined:
  - Adds input i_mask[3:0]; a 1 bit skips that slot.
  - Each advance moves o_ctrl to the next unmasked slot in circular order after the current one.
  - o_wrap pulses when the new index <= the old index.
  - Entry into SCAN selects the lowest unmasked slot.
  - If all four bits are set, o_ctrl holds its value and o_wrap stays 0; cnt still counts and stop handling is unchanged.
  - Mask changes take effect at the next advance.
- Not defined: no i_mask port; all four slots are visited in order 0,1,2,3.

Test Plan:
- Reset then write:
  - Stimulus: assert i_rst; write 16'hA5A5->slot2 and 16'h0001->slot0.
  - Required: all outputs 0 during reset; o_data_2=A5A5 and o_data_0=0001 one cycle after each write.
- Scan timing (DWELL=4):
  - Stimulus: pulse i_start.
  - Required: o_ctrl sequence 0,0,0,0,1,1,1,1,2,...; after 16 cycles o_ctrl=0 with o_wrap=1 for one cycle; o_busy=1 throughout.
- Stop mid-dwell:
  - Stimulus: i_stop on the 2nd cycle of slot 1.
  - Required: o_ctrl stays 1 for 2 more cycles, then 0 with o_busy=0; no o_wrap.
- Stop on last dwell cycle:
  - Stimulus: i_stop when cnt==3 on slot 2.
  - Required: next cycle o_ctrl=0, IDLE, no advance to 3.
- Simultaneous and asynchronous events:
  - i_start+i_stop together in IDLE -> stays IDLE.
  - i_rst asserted mid-SCAN -> o_ctrl=0 and o_busy=0 immediately, without waiting for a clock edge.
- Mask (REG4_SCAN_MASK_EN, DWELL=1):
  - i_mask=4'b0101 -> o_ctrl 1,3,1,3 with o_wrap on each 3->1.
  - i_mask=4'b1111 -> o_ctrl constant.

Source files
------------

// File: rtl/reg4_scan_seq_if.sv
// Bus bundle for reg4_scan_seq: slot write port, scan commands and the
// mux-facing outputs. Optional i_mask exists only with REG4_SCAN_MASK_EN.
interface reg4_scan_seq_if #(
    parameter int unsigned WIDTH = 16
);
    logic             i_wr_en;
    logic [1:0]       i_wr_addr;
    logic [WIDTH-1:0] i_wr_data;
    logic             i_start;
    logic             i_stop;
`ifdef REG4_SCAN_MASK_EN
    logic [3:0]       i_mask;
`endif
    logic [WIDTH-1:0] o_data_0;
    logic [WIDTH-1:0] o_data_1;
    logic [WIDTH-1:0] o_data_2;
    logic [WIDTH-1:0] o_data_3;
    logic [1:0]       o_ctrl;
    logic             o_busy;
    logic             o_wrap;

`ifdef REG4_SCAN_MASK_EN
    modport master (
        output i_wr_en, i_wr_addr, i_wr_data, i_start, i_stop, i_mask,
        input  o_data_0, o_data_1, o_data_2, o_data_3, o_ctrl, o_busy, o_wrap
    );
    modport slave (
        input  i_wr_en, i_wr_addr, i_wr_data, i_start, i_stop, i_mask,
        output o_data_0, o_data_1, o_data_2, o_data_3, o_ctrl, o_busy, o_wrap
    );
`else
    modport master (
        output i_wr_en, i_wr_addr, i_wr_data, i_start, i_stop,
        input  o_data_0, o_data_1, o_data_2, o_data_3, o_ctrl, o_busy, o_wrap
    );
    modport slave (
        input  i_wr_en, i_wr_addr, i_wr_data, i_start, i_stop,
        output o_data_0, o_data_1, o_data_2, o_data_3, o_ctrl, o_busy, o_wrap
    );
`endif
endinterface

// File: rtl/reg4_scan_seq.sv
// reg4_scan_seq: four slot registers feeding a registered 4:1 mux plus a
// timed round-robin select scanner (DWELL cycles per slot).
// Optional slot skipping is enabled by defining REG4_SCAN_MASK_EN.
module reg4_scan_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DWELL = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    reg4_scan_seq_if.slave    bus
);
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SCAN     = 2'd1,
        S_STOPPING = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nx;
    logic [1:0]       r_ctrl;
    logic [1:0]       w_ctrl_nx;
    logic             r_wrap;
    logic             w_wrap_nx;
    logic             r_busy;
    logic             w_busy_nx;
    logic             w_last;
    logic [1:0]       w_adv_ctrl;
    logic             w_adv_wrap;
    logic [1:0]       w_entry_ctrl;
    logic [WIDTH-1:0] r_data_0;
    logic [WIDTH-1:0] r_data_1;
    logic [WIDTH-1:0] r_data_2;
    logic [WIDTH-1:0] r_data_3;

`ifdef REG4_SCAN_MASK_EN
    // First unmasked slot strictly after cur in circular order; cur if none.
    function automatic logic [1:0] f_next_slot(input logic [1:0] cur, input logic [3:0] mask);
        logic [1:0] res;
        logic [1:0] idx;
        res = cur;
        for (int k = 4; k >= 1; k--) begin
            idx = cur + 2'(k);
            if (!mask[idx]) res = idx;
        end
        return res;
    endfunction

    // Lowest unmasked slot; 0 when everything is masked.
    function automatic logic [1:0] f_first_slot(input logic [3:0] mask);
        logic [1:0] res;
        res = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (!mask[k]) res = 2'(k);
        end
        return res;
    endfunction

    // Masked advance: hold and no wrap when all slots are skipped.
    always_comb begin
        w_adv_ctrl   = f_next_slot(r_ctrl, bus.i_mask);
        w_adv_wrap   = !(&bus.i_mask) && (w_adv_ctrl <= r_ctrl);
        w_entry_ctrl = f_first_slot(bus.i_mask);
    end
`else
    // Plain round robin 0,1,2,3.
    always_comb begin
        w_adv_ctrl   = r_ctrl + 2'd1;
        w_adv_wrap   = (r_ctrl == 2'd3);
        w_entry_ctrl = 2'd0;
    end
`endif

    // Slot registers, writable in every scan state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_data_0 <= '0;
            r_data_1 <= '0;
            r_data_2 <= '0;
            r_data_3 <= '0;
        end else if (bus.i_wr_en) begin
            case (bus.i_wr_addr)
                2'd0:    r_data_0 <= bus.i_wr_data;
                2'd1:    r_data_1 <= bus.i_wr_data;
                2'd2:    r_data_2 <= bus.i_wr_data;
                default: r_data_3 <= bus.i_wr_data;
            endcase
        end
    end

    // Scanner state, dwell counter and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ctrl  <= 2'd0;
            r_wrap  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_ctrl  <= w_ctrl_nx;
            r_wrap  <= w_wrap_nx;
            r_busy  <= w_busy_nx;
        end
    end

    // Next-state logic; a stop on the last dwell cycle exits without advancing.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_ctrl_nx  = r_ctrl;
        w_wrap_nx  = 1'b0;
        w_last     = (r_cnt == LAST_CNT);

        case (r_state)
            S_IDLE: begin
                w_cnt_nx  = '0;
                w_ctrl_nx = 2'd0;
                if (bus.i_start && !bus.i_stop) begin
                    w_state_nx = S_SCAN;
                    w_ctrl_nx  = w_entry_ctrl;
                end
            end
            S_SCAN: begin
                if (w_last) begin
                    w_cnt_nx = '0;
                    if (bus.i_stop) begin
                        w_state_nx = S_IDLE;
                        w_ctrl_nx  = 2'd0;
                    end else begin
                        w_ctrl_nx = w_adv_ctrl;
                        w_wrap_nx = w_adv_wrap;
                    end
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                    if (bus.i_stop) w_state_nx = S_STOPPING;
                end
            end
            S_STOPPING: begin
                if (w_last) begin
                    w_state_nx = S_IDLE;
                    w_cnt_nx   = '0;
                    w_ctrl_nx  = 2'd0;
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_cnt_nx   = '0;
                w_ctrl_nx  = 2'd0;
            end
        endcase

        w_busy_nx = (w_state_nx != S_IDLE);
    end

    assign bus.o_data_0 = r_data_0;
    assign bus.o_data_1 = r_data_1;
    assign bus.o_data_2 = r_data_2;
    assign bus.o_data_3 = r_data_3;
    assign bus.o_ctrl   = r_ctrl;
    assign bus.o_busy   = r_busy;
    assign bus.o_wrap   = r_wrap;
endmodule

// File: tb/tb_reg4_scan_seq.sv
// Directed bench for reg4_scan_seq: DWELL=4 main instance plus a DWELL=1
// instance. Mask steps are compiled in when REG4_SCAN_MASK_EN is defined.
module tb_reg4_scan_seq;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_fail;

    reg4_scan_seq_if #(.WIDTH(16)) bus  ();
    reg4_scan_seq_if #(.WIDTH(16)) bus1 ();

    reg4_scan_seq #(.WIDTH(16), .DWELL(4)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    reg4_scan_seq #(.WIDTH(16), .DWELL(1)) dut1 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_vec  = 0;
        n_fail = 0;
        rst    = 1'b1;
        bus.i_wr_en = 1'b0;  bus.i_wr_addr = 2'd0;  bus.i_wr_data = 16'h0;
        bus.i_start = 1'b0;  bus.i_stop = 1'b0;
        bus1.i_wr_en = 1'b0; bus1.i_wr_addr = 2'd0; bus1.i_wr_data = 16'h0;
        bus1.i_start = 1'b0; bus1.i_stop = 1'b0;
`ifdef REG4_SCAN_MASK_EN
        bus.i_mask  = 4'b0000;
        bus1.i_mask = 4'b0000;
`endif

        // Reset holds everything at zero even with a write presented.
        bus.i_wr_en = 1'b1; bus.i_wr_addr = 2'd2; bus.i_wr_data = 16'hA5A5;
        tick();
        check("rst_data2", 32'(bus.o_data_2), 32'h0);
        check("rst_ctrl",  32'(bus.o_ctrl),   32'h0);
        check("rst_busy",  32'(bus.o_busy),   32'h0);
        check("rst_wrap",  32'(bus.o_wrap),   32'h0);
        rst = 1'b0;

        // Writes land one edge later.
        tick();
        check("wr_data2", 32'(bus.o_data_2), 32'hA5A5);
        bus.i_wr_addr = 2'd0; bus.i_wr_data = 16'h0001;
        tick();
        bus.i_wr_en = 1'b0;
        check("wr_data0",      32'(bus.o_data_0), 32'h0001);
        check("wr_data2_hold", 32'(bus.o_data_2), 32'hA5A5);
        check("idle_busy",     32'(bus.o_busy),   32'h0);

        // Scan: 4 cycles per slot, stray start ignored, write to slot 3 mid-scan.
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            check($sformatf("scan_ctrl_%0d", k), 32'(bus.o_ctrl), 32'(k / 4));
            check($sformatf("scan_busy_%0d", k), 32'(bus.o_busy), 32'h1);
            check($sformatf("scan_wrap_%0d", k), 32'(bus.o_wrap), 32'h0);
            if (k == 5) bus.i_start = 1'b1;
            if (k == 9) begin
                bus.i_wr_en = 1'b1; bus.i_wr_addr = 2'd3; bus.i_wr_data = 16'hBEEF;
            end
            tick();
            bus.i_start = 1'b0;
            bus.i_wr_en = 1'b0;
        end
        check("wrap_ctrl",   32'(bus.o_ctrl), 32'h0);
        check("wrap_pulse",  32'(bus.o_wrap), 32'h1);
        check("wrap_busy",   32'(bus.o_busy), 32'h1);
        check("mid_wr_data3", 32'(bus.o_data_3), 32'hBEEF);
        tick();
        check("wrap_once", 32'(bus.o_wrap), 32'h0);
        check("wrap_ctrl2", 32'(bus.o_ctrl), 32'h0);

        // Stop on the 2nd cycle of slot 1: slot finishes its dwell.
        tick(); tick(); tick(); tick();
        check("pre_stop_ctrl", 32'(bus.o_ctrl), 32'h1);
        bus.i_stop = 1'b1;
        tick();
        bus.i_stop = 1'b0;
        check("stopping_ctrl", 32'(bus.o_ctrl), 32'h1);
        check("stopping_busy", 32'(bus.o_busy), 32'h1);
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        check("stopping_ctrl2", 32'(bus.o_ctrl), 32'h1);
        check("stopping_busy2", 32'(bus.o_busy), 32'h1);
        tick();
        check("stopped_ctrl", 32'(bus.o_ctrl), 32'h0);
        check("stopped_busy", 32'(bus.o_busy), 32'h0);
        check("stopped_wrap", 32'(bus.o_wrap), 32'h0);
        tick();
        check("stopped_stays", 32'(bus.o_busy), 32'h0);

        // Stop exactly on the last dwell cycle of slot 2.
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        for (int k = 0; k < 11; k++) tick();
        check("last_pre_ctrl", 32'(bus.o_ctrl), 32'h2);
        bus.i_stop = 1'b1;
        tick();
        bus.i_stop = 1'b0;
        check("last_stop_ctrl", 32'(bus.o_ctrl), 32'h0);
        check("last_stop_busy", 32'(bus.o_busy), 32'h0);
        check("last_stop_wrap", 32'(bus.o_wrap), 32'h0);
        tick();
        check("last_stop_idle", 32'(bus.o_ctrl), 32'h0);

        // Start and stop together in IDLE: stop wins.
        bus.i_start = 1'b1; bus.i_stop = 1'b1;
        tick();
        bus.i_start = 1'b0; bus.i_stop = 1'b0;
        check("both_busy", 32'(bus.o_busy), 32'h0);
        tick();
        check("both_busy2", 32'(bus.o_busy), 32'h0);

        // Asynchronous reset mid-scan clears outputs before any edge.
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        check("pre_rst_ctrl", 32'(bus.o_ctrl), 32'h1);
        rst = 1'b1;
        #1;
        check("async_ctrl",  32'(bus.o_ctrl),   32'h0);
        check("async_busy",  32'(bus.o_busy),   32'h0);
        check("async_data2", 32'(bus.o_data_2), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_busy", 32'(bus.o_busy), 32'h0);

        // DWELL=1: slot advances every cycle.
        bus1.i_start = 1'b1;
        tick();
        bus1.i_start = 1'b0;
        check("d1_ctrl0", 32'(bus1.o_ctrl), 32'h0);
        check("d1_busy",  32'(bus1.o_busy), 32'h1);
        tick(); check("d1_ctrl1", 32'(bus1.o_ctrl), 32'h1);
        tick(); check("d1_ctrl2", 32'(bus1.o_ctrl), 32'h2);
        tick(); check("d1_ctrl3", 32'(bus1.o_ctrl), 32'h3);
        check("d1_nowrap", 32'(bus1.o_wrap), 32'h0);
        tick();
        check("d1_wrap_ctrl", 32'(bus1.o_ctrl), 32'h0);
        check("d1_wrap",      32'(bus1.o_wrap), 32'h1);
        tick();
        check("d1_ctrl1b", 32'(bus1.o_ctrl), 32'h1);
        check("d1_wrap0",  32'(bus1.o_wrap), 32'h0);
        bus1.i_stop = 1'b1;
        tick();
        bus1.i_stop = 1'b0;
        check("d1_stop_ctrl", 32'(bus1.o_ctrl), 32'h0);
        check("d1_stop_busy", 32'(bus1.o_busy), 32'h0);

`ifdef REG4_SCAN_MASK_EN
        // Mask 0101 on DWELL=4: visits 1,3,1 with wrap on 3->1; then all masked holds.
        bus.i_mask = 4'b0101;
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        check("m_entry", 32'(bus.o_ctrl), 32'h1);
        for (int k = 0; k < 4; k++) tick();
        check("m_ctrl3",  32'(bus.o_ctrl), 32'h3);
        check("m_nowrap", 32'(bus.o_wrap), 32'h0);
        for (int k = 0; k < 4; k++) tick();
        check("m_ctrl1", 32'(bus.o_ctrl), 32'h1);
        check("m_wrap",  32'(bus.o_wrap), 32'h1);
        bus.i_mask = 4'b1111;
        for (int k = 0; k < 4; k++) tick();
        check("m_all_hold",   32'(bus.o_ctrl), 32'h1);
        check("m_all_nowrap", 32'(bus.o_wrap), 32'h0);
        check("m_all_busy",   32'(bus.o_busy), 32'h1);
        bus.i_stop = 1'b1;
        tick();
        bus.i_stop = 1'b0;
        tick(); tick(); tick();
        check("m_stop_busy", 32'(bus.o_busy), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
